// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive stage: 8 data bits LSB first, optional parity, 1 stop bit.
// Samples each bit at mid-bit from the synchronized start edge; flags parity and framing errors.
module uart_receiver #(
  parameter int CLK_FREQ             = 50_000_000,
  parameter int BAUD_RATE            = 9_600,
  parameter int CLOCK_CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int PARITY_EN            = 1,
  parameter int PARITY_ODD           = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [3:0] led
);

  localparam logic [31:0] LAST    = 32'(CLOCK_CYCLES_PER_BIT - 1);
  localparam logic [31:0] HALF_M1 = 32'((CLOCK_CYCLES_PER_BIT / 2) - 1);
  localparam logic        PAR_EN  = (PARITY_EN != 0);
  localparam logic        PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BREAK
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_d;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        perr;
  logic        stop_sample;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_d        <= 1'b1;
      state       <= IDLE;
      cnt         <= 32'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      perr        <= 1'b0;
      stop_sample <= 1'b1;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      led         <= 4'd0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_d     <= rx_s;
      rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            cnt   <= 32'd0;
            state <= START;
            busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit so short glitches are dropped.
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= 32'd0;
            if (!rx_s) begin
              bit_idx <= 3'd0;
              state   <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        DATA: begin
          if (cnt == LAST) begin
            cnt            <= 32'd0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= PAR_EN ? PARITY : STOP;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        PARITY: begin
          if (cnt == LAST) begin
            cnt   <= 32'd0;
            perr  <= (^shift) ^ rx_s ^ PAR_ODD;
            state <= STOP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        STOP: begin
          if (cnt == LAST) begin
            cnt         <= 32'd0;
            stop_sample <= rx_s;
            state       <= DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        DONE: begin
          rx_data    <= shift;
          rx_valid   <= 1'b1;
          parity_err <= PAR_EN & perr;
          frame_err  <= ~stop_sample;
          if (!(PAR_EN & perr) && stop_sample) begin
            led <= shift[4:1];
          end
          if (stop_sample) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= BREAK;
          end
        end

        // A line held low after a bad stop bit must go high before a new start is accepted.
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage that consumes the single-wire Tx line of the board's UART sender and recovers each frame. Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1). Each frame produces a one-cycle valid pulse with the data byte and error flags. The 4-bit payload field is also latched onto LED outputs for board-level loopback demos.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9_600, line bit rate
CLOCK_CYCLES_PER_BIT, CLK_FREQ/BAUD_RATE (5208), clocks per bit; must be >= 4
PARITY_EN, 1, 1 = a parity bit is present between data and stop
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
rx  in  1  asynchronous serial input, idle high
rx_data  out  8  last received byte, held until the next frame completes
rx_valid  out  1  one-cycle pulse on frame completion
parity_err  out  1  parity mismatch for the frame flagged by rx_valid
frame_err  out  1  stop bit sampled low for the frame flagged by rx_valid
busy  out  1  high in every state except IDLE
led  out  4  rx_data[4:1] of the last error-free frame

Behaviour:
- Reset values (rst=0 at clk edge): rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, led=0. Synchronizer flops reset to 1. State=IDLE, counters=0. A reset asserted mid-frame discards the partial frame with no rx_valid.
- Input sync: rx passes through 2 flops to form rx_s. All decisions use rx_s only. A third flop, rx_d, detects falling edges.
- Bit counter: 32-bit. It counts 0..CLOCK_CYCLES_PER_BIT-1, then wraps to 0. HALF = CLOCK_CYCLES_PER_BIT/2 (integer divide).
- States:
  - IDLE: on rx_d=1 and rx_s=0, clear the counter and go to START.
  - START: count to HALF-1. If rx_s=0 at that count, clear the counter, set bit_idx=0, and go to DATA. If rx_s=1, treat as a glitch and return to IDLE with no outputs changed.
  - DATA: at count CLOCK_CYCLES_PER_BIT-1, shift rx_s into shift[bit_idx] and increment bit_idx. After bit_idx 7 is sampled, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: at count CLOCK_CYCLES_PER_BIT-1, set perr = (^shift ^ rx_s ^ PARITY_ODD). Go to STOP.
  - STOP: at count CLOCK_CYCLES_PER_BIT-1, sample rx_s and go to DONE.
  - DONE (1 cycle):
    - Load rx_data=shift and assert rx_valid=1.
    - Set parity_err=perr (0 when PARITY_EN=0) and frame_err = ~stop_sample.
    - Update led=shift[4:1] only if both errors are 0.
    - Next state: IDLE if stop_sample=1, else BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line never re-triggers a frame.
- Sample points land at mid-bit, from (HALF + k*CLOCK_CYCLES_PER_BIT) after the synchronized falling edge.
- Latency: rx_valid rises 3 + HALF + (9 + PARITY_EN)*CLOCK_CYCLES_PER_BIT + 1 clocks (±1) after the rx falling edge at the pin.
- rx_valid is high for exactly one cycle per frame and is never asserted for a glitch or aborted frame.
- parity_err and frame_err hold their values until the next DONE.
- Back-to-back frames: a start edge immediately after the stop bit must be accepted. DONE returns to IDLE one cycle after the stop sample, leaving about HALF cycles of margin.

Test Plan:
(Benches use CLK_FREQ=1_000_000 and BAUD_RATE=100_000, so CLOCK_CYCLES_PER_BIT=10 and HALF=5. PARITY_EN=1, PARITY_ODD=0.)
1. Frame 0x5A, parity 0, stop 1 -> one rx_valid pulse, rx_data=0x5A, parity_err=0, frame_err=0, led=4'b1101, busy low after DONE.
2. Frame 0x5A with parity bit 1 -> rx_valid pulse, rx_data=0x5A, parity_err=1, led keeps its prior value.
3. Frame 0x01, parity 1, stop bit driven 0 and line held low 50 clks -> rx_valid pulse, frame_err=1, busy stays high until rx returns to 1, then no extra frame.
4. rx low for 3 clks then high -> no rx_valid, state returns to IDLE, busy pulses high less than 10 clks.
5. rst=0 for 1 clk after 4 data bits of 0x33, then full frame 0xA5 (parity 0) -> no pulse for 0x33, one pulse with rx_data=0xA5, led=4'b0010.
6. Back-to-back 0x01 (parity 1) then 0xFF (parity 0) with zero idle bits -> two rx_valid pulses, 0x01 then 0xFF, both error-free, led ends at 4'b1111.
